// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback (fixed highest priority, never back-pressured) and a
//   long-latency unit (mul/div) that hands over results with valid/ready.
//   Long-latency results wait in a 2-entry FIFO until the pipeline leaves the
//   write slot free. If they wait too long, a stall request is raised so the
//   hazard unit can freeze the pipeline and let the FIFO drain.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   pipe_regwrite      pipeline writeback valid (MEM/WB)
//   pipe_rd[4:0]       pipeline destination register
//   pipe_result[31:0]  pipeline writeback data
//   lu_valid           long-latency result valid
//   lu_rd[4:0]         long-latency destination register
//   lu_data[31:0]      long-latency result data
//   lu_ready           FIFO can take a result this cycle
//   rf_we              register-file write enable (registered)
//   rf_waddr[4:0]      register-file write address (registered)
//   rf_wdata[31:0]     register-file write data (registered)
//   stall_req          freeze request to the hazard unit (registered)
//   lu_busy            FIFO holds at least one entry
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_regwrite,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_result,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic        lu_busy
);

    localparam int         DATA_W = 32;
    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [3:0]        starve_cnt;
    logic [4:0]        fifo_rd   [2];
    logic [DATA_W-1:0] fifo_data [2];

    logic              pipe_live;
    logic              push;
    logic              pop;
    logic [1:0]        count_next;
    logic [3:0]        starve_next;
    logic              stall_next;
    logic              we_next;
    logic [4:0]        waddr_next;
    logic [DATA_W-1:0] wdata_next;

    // Writes to x0 are not real requests, so they leave the slot to the FIFO.
    assign pipe_live = pipe_regwrite && (pipe_rd != 5'd0);

    // Ready comes from the registered count only: a full FIFO refuses a push
    // even in a cycle where it also pops.
    assign lu_ready = (count != 2'd2);
    assign lu_busy  = (count != 2'd0);
    assign push     = lu_valid && lu_ready;

    // Using the registered count means an entry pushed this edge cannot be
    // popped until the next cycle (no bypass).
    assign pop      = !pipe_live && (count != 2'd0);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    always_comb begin
        we_next    = 1'b0;
        waddr_next = 5'd0;
        wdata_next = '0;
        if (pipe_live) begin
            we_next    = 1'b1;
            waddr_next = pipe_rd;
            wdata_next = pipe_result;
        end else if (pop) begin
            // A buffered x0 result is dropped but still uses up the slot.
            we_next    = (fifo_rd[rd_ptr] != 5'd0);
            waddr_next = fifo_rd[rd_ptr];
            wdata_next = fifo_data[rd_ptr];
        end
    end

    // Starvation counts edges where the FIFO waited and the pipeline won.
    always_comb begin
        starve_next = 4'd0;
        if (pipe_live && (count != 2'd0)) begin
            starve_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
        end
    end

    // Stall rises one edge after the limit is hit and holds until the FIFO
    // drains; the counter itself clears on the first pop.
    always_comb begin
        stall_next = stall_req;
        if (count_next == 2'd0) begin
            stall_next = 1'b0;
        end else if (starve_cnt == LIMIT) begin
            stall_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            starve_cnt <= 4'd0;
            stall_req  <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= '0;
        end else begin
            count      <= count_next;
            starve_cnt <= starve_next;
            stall_req  <= stall_next;
            rf_we      <= we_next;
            rf_waddr   <= waddr_next;
            rf_wdata   <= wdata_next;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // FIFO storage is data only; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lu_rd;
            fifo_data[wr_ptr] <= lu_data;
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive denied cycles before stall_req asserts; legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pipe_regwrite  input  1  pipeline writeback valid, from MEM/WB register.
REQ-005 pipe_rd  input  5  pipeline destination register.
REQ-006 pipe_result  input  32  pipeline writeback data.
REQ-007 lu_valid  input  1  long-latency unit (mul/div) result valid.
REQ-008 lu_rd  input  5  long-latency unit destination register.
REQ-009 lu_data  input  32  long-latency unit result data.
REQ-010 lu_ready  output  1  arbiter can accept an lu result this cycle.
REQ-011 rf_we  output  1  register file write enable, registered.
REQ-012 rf_waddr  output  5  register file write address, registered.
REQ-013 rf_wdata  output  32  register file write data, registered.
REQ-014 stall_req  output  1  request to hazard unit to freeze pipeline, registered.
REQ-015 lu_busy  output  1  lu FIFO non-empty, registered-state derived.

Function
REQ-016 The block SHALL share the single register-file write port between the pipeline (fixed highest priority, no backpressure) and the lu unit (valid/ready handshake).
REQ-017 lu results SHALL be buffered in a 2-entry FIFO of {rd, data}; push on lu_valid && lu_ready.
REQ-018 lu_ready SHALL equal (count < 2) from registered count only; no push when full even if a pop occurs that cycle.
REQ-019 Pipeline request is live when pipe_regwrite=1 and pipe_rd!=0; pipe_regwrite with pipe_rd=0 SHALL leave the slot free and produce no write.
REQ-020 Each cycle: live pipeline request -> next-edge rf_we=1, rf_waddr=pipe_rd, rf_wdata=pipe_result; else FIFO non-empty -> pop head, write its rd/data; else rf_we=0.
REQ-021 Pipeline write latency SHALL be exactly 1 cycle (inputs at edge t appear on rf_* after edge t).
REQ-022 An lu entry pushed at edge t SHALL be eligible for pop no earlier than the following cycle (no bypass); minimum push-to-rf_we latency 2 edges.
REQ-023 A popped entry with rd=0 SHALL be discarded with rf_we=0 and consume the slot.
REQ-024 FIFO order SHALL be strict FIFO; wrap-around of 1-bit read/write pointers SHALL be transparent.
REQ-025 Starvation counter (4 bits) SHALL increment each cycle FIFO is non-empty and the pipeline wins the slot; clear on any pop or when FIFO empty; saturate at STARVE_LIMIT.
REQ-026 stall_req SHALL assert on the edge after the counter reaches STARVE_LIMIT and remain asserted until the edge at which the FIFO becomes empty.
REQ-027 If a live pipeline request arrives while stall_req=1, the pipeline SHALL still win (no write is ever dropped); counter keeps running.
REQ-028 Simultaneous push and pop with count=1 SHALL leave count=1 with the new entry at head next cycle.
REQ-029 lu_busy SHALL equal (count != 0).

Reset
REQ-030 While reset=1: rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, count=0, pointers=0, starvation counter=0; lu_ready=1, lu_busy=0.
REQ-031 Reset mid-operation SHALL discard all buffered lu entries; no write occurs for them after release.
REQ-032 First write after release SHALL follow REQ-020 on the first clk edge with reset=0.

Verification
REQ-033 Pipe only: pipe_regwrite=1, rd=5, result=0xDEADBEEF, lu idle -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF.
REQ-034 Contention: lu push rd=7 data=0x11 at t, pipe live rd=3 at t+1 -> rf writes rd=3 at t+2, rd=7 at t+3.
REQ-035 Full FIFO: two lu pushes, pipeline live continuously -> lu_ready=0 after second push; with STARVE_LIMIT=4, stall_req=1 after 5th denied edge; drop pipe_regwrite -> entries written in order, stall_req=0 the edge FIFO empties.
REQ-036 x0: pipe rd=0 with lu entry rd=9 buffered -> rd=9 written that slot; lu entry rd=0 -> popped, rf_we=0, lu_busy falls.
REQ-037 Reset with 2 entries buffered -> all outputs 0, lu_ready=1; after release with no inputs rf_we stays 0.
